// File: rtl/delay_meter.sv
// delay_meter
//
// Measures, in clock cycles, how long a combinational DUT's single-bit
// response keeps moving after each stimulus change, and how many response
// transitions (glitches) occur before it settles. Results are reported
// through a valid/ack handshake.
//
// Parameters:
//   W_STIM  - stimulus vector width
//   W_CNT   - latency counter width
//   SETTLE  - consecutive quiet cycles that declare the response settled (1..15)
//   TIMEOUT - cycle limit per measurement (< 2**W_CNT)
//
// Ports:
//   i_clk      - system clock, rising edge
//   i_reset    - asynchronous active-high reset
//   i_stim     - stimulus vector driven into the DUT
//   i_resp     - DUT response
//   i_ack      - consumer accepts the pending report
//   o_valid    - report available
//   o_latency  - cycle index of the last response change (TIMEOUT on timeout)
//   o_edges    - response transitions in the window, saturating at 15
//   o_timeout  - measurement ended by TIMEOUT
//   o_busy     - measurement in progress
//   o_missed   - sticky: a stimulus change arrived while a report was pending
module delay_meter #(
    parameter int unsigned W_STIM  = 3,
    parameter int unsigned W_CNT   = 8,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [W_STIM-1:0] i_stim,
    input  logic              i_resp,
    input  logic              i_ack,
    output logic              o_valid,
    output logic [W_CNT-1:0]  o_latency,
    output logic [3:0]        o_edges,
    output logic              o_timeout,
    output logic              o_busy,
    output logic              o_missed
);

    typedef enum logic [1:0] {
        StIdle,
        StMeasure,
        StReport
    } state_e;

    localparam logic [W_CNT-1:0] CntOne     = W_CNT'(1);
    localparam logic [W_CNT:0]   CntTwo     = (W_CNT + 1)'(2);
    localparam logic [W_CNT-1:0] TimeoutCnt = W_CNT'(TIMEOUT);
    localparam logic [W_CNT:0]   TimeoutExt = (W_CNT + 1)'(TIMEOUT);
    localparam logic [3:0]       SettleCnt  = 4'(SETTLE);

    state_e             state_q, state_d;
    logic [W_STIM-1:0]  stim_q;
    logic               resp_q;
    logic [W_CNT-1:0]   cnt_q, cnt_d;
    logic [3:0]         quiet_q, quiet_d;
    logic [3:0]         edges_q, edges_d;
    logic [W_CNT-1:0]   last_q, last_d;
    logic [W_CNT-1:0]   latency_q, latency_d;
    logic [3:0]         rep_edges_q, rep_edges_d;
    logic               timeout_q, timeout_d;
    logic               missed_q, missed_d;
    logic               valid_q, busy_q;

    logic               stim_chg;
    logic               resp_chg;
    logic [W_CNT-1:0]   cnt_inc;
    logic [3:0]         quiet_inc;
    logic               settled;
    logic               timeout_hit;

    always_comb begin
        stim_chg    = (i_stim != stim_q);
        resp_chg    = (i_resp != resp_q);
        cnt_inc     = cnt_q + CntOne;
        quiet_inc   = quiet_q + 4'd1;
        settled     = !resp_chg && (quiet_inc == SettleCnt);
        // The window closes when the count after this edge, plus one, reaches
        // TIMEOUT, so the report lands after edge E(TIMEOUT-1).
        timeout_hit = (({1'b0, cnt_q} + CntTwo) >= TimeoutExt);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quiet_d     = quiet_q;
        edges_d     = edges_q;
        last_d      = last_q;
        latency_d   = latency_q;
        rep_edges_d = rep_edges_q;
        timeout_d   = timeout_q;
        missed_d    = missed_q;

        case (state_q)
            StIdle, StMeasure: begin
                if (stim_chg) begin
                    // Fresh window, also used to restart a running measurement.
                    state_d = StMeasure;
                    cnt_d   = '0;
                    quiet_d = 4'd0;
                    last_d  = '0;
                    edges_d = resp_chg ? 4'd1 : 4'd0;
                end else if (state_q == StMeasure) begin
                    cnt_d = cnt_inc;
                    if (resp_chg) begin
                        last_d  = cnt_inc;
                        edges_d = (edges_q == 4'd15) ? 4'd15 : edges_q + 4'd1;
                        quiet_d = 4'd0;
                    end else begin
                        quiet_d = quiet_inc;
                    end
                    if (settled) begin
                        state_d     = StReport;
                        latency_d   = last_q;
                        rep_edges_d = edges_q;
                        timeout_d   = 1'b0;
                    end else if (timeout_hit) begin
                        state_d     = StReport;
                        latency_d   = TimeoutCnt;
                        rep_edges_d = edges_d;
                        timeout_d   = 1'b1;
                    end
                end
            end
            StReport: begin
                // Stimulus changes here, including on the ack edge, are dropped.
                if (stim_chg) begin
                    missed_d = 1'b1;
                end
                if (i_ack) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= StIdle;
            stim_q      <= '0;
            resp_q      <= 1'b0;
            cnt_q       <= '0;
            quiet_q     <= 4'd0;
            edges_q     <= 4'd0;
            last_q      <= '0;
            latency_q   <= '0;
            rep_edges_q <= 4'd0;
            timeout_q   <= 1'b0;
            missed_q    <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stim_q      <= i_stim;
            resp_q      <= i_resp;
            cnt_q       <= cnt_d;
            quiet_q     <= quiet_d;
            edges_q     <= edges_d;
            last_q      <= last_d;
            latency_q   <= latency_d;
            rep_edges_q <= rep_edges_d;
            timeout_q   <= timeout_d;
            missed_q    <= missed_d;
            valid_q     <= (state_d == StReport);
            busy_q      <= (state_d == StMeasure);
        end
    end

    assign o_valid   = valid_q;
    assign o_busy    = busy_q;
    assign o_latency = latency_q;
    assign o_edges   = rep_edges_q;
    assign o_timeout = timeout_q;
    assign o_missed  = missed_q;

endmodule

// File: doc/delay_meter.md
# delay_meter

Sequential measurement block that sits at the response end of a stimulus/DUT pair. It watches a stimulus vector driven into a gate-level combinational DUT and the DUT's single-bit response, both sampled on the system clock. For every stimulus change it measures, in clock cycles, when the response last changed and how many response transitions (glitches) occurred before the response settled. It reports the result through a valid/ack handshake.

## Interface
- W_STIM, default 3: stimulus vector width.
- W_CNT, default 8: latency counter width.
- SETTLE, default 4: consecutive quiet cycles that declare the response settled; range 1..15.
- TIMEOUT, default 200: cycle limit per measurement; must be < 2**W_CNT.

Ports:
- i_clk  in  1  system clock, rising edge; one clock domain.
- i_reset  in  1  asynchronous, active-high reset.
- i_stim  in  W_STIM  stimulus vector, synchronous to i_clk.
- i_resp  in  1  DUT response, synchronous to i_clk.
- i_ack  in  1  consumer accepts the report.
- o_valid  out  1  report available.
- o_latency  out  W_CNT  cycle index of the last response change (0 if none).
- o_edges  out  4  response transitions in the window, saturating at 15.
- o_timeout  out  1  measurement ended by TIMEOUT.
- o_busy  out  1  measurement in progress.
- o_missed  out  1  sticky: a stimulus change arrived while a report was pending.

## Operation
- Registers stim_q and resp_q hold the previous samples. Both update on every clock edge in every state.
- A stimulus change is i_stim != stim_q. A response change is i_resp != resp_q.
- The state machine has three states: IDLE, MEASURE and REPORT.
- IDLE, on a stimulus change:
  - Go to MEASURE; cnt=0, quiet=0.
  - If the response also changed on the same edge: edges=1, last=0. Otherwise edges=0, last=0.
- MEASURE, on each edge:
  - cnt increments.
  - A response change sets last=cnt+1, increments edges (saturating at 15) and clears quiet. Otherwise quiet increments.
  - quiet reaching SETTLE: go to REPORT with o_latency=last, o_timeout=0.
  - Otherwise, cnt+1 reaching TIMEOUT: go to REPORT with o_latency=TIMEOUT, o_timeout=1.
  - Settle takes priority over timeout on the same edge.
  - A new stimulus change restarts the measurement exactly as the IDLE entry does. Restart takes priority over settle and timeout.
- REPORT:
  - o_valid=1; o_latency, o_edges and o_timeout are held stable.
  - i_ack=1 on an edge: go to IDLE, o_valid=0.
  - A stimulus change while in REPORT is dropped and sets o_missed=1. o_missed is cleared only by reset.
  - A stimulus change on the same edge as the ack is also dropped and sets o_missed.
- o_busy=1 exactly in MEASURE.
- Reset mid-operation aborts any measurement or pending report immediately.

## Timing
- Reset values:
  - State IDLE.
  - o_valid, o_busy, o_timeout and o_missed are 0.
  - o_latency and o_edges are 0.
  - stim_q and resp_q are 0.
- All outputs are registered; none is combinational from the inputs.
- Let E0 be the edge that detects the stimulus change. o_busy is high after E0.
- A response change detected at edge Ek gives latency k.
- Report timing:
  - With no response change, o_valid rises after edge E(SETTLE).
  - With a last change at Ek, o_valid rises after edge E(k+SETTLE).
  - On timeout, o_valid rises after edge E(TIMEOUT−1).
- o_valid holds until the ack edge; the earliest measurement restart is the edge after the ack.
- An i_ack outside REPORT is ignored.

## Test plan
- Reset: assert i_reset asynchronously in MEASURE (between edges) -> all outputs 0 immediately; state IDLE.
- Clean transition: stim 3'b111→3'b110 at E0; resp changes 1→0 detected at E2; ack at the first o_valid cycle.
  - Required: o_valid high after E6, o_latency=2, o_edges=1, o_timeout=0.
  - Then IDLE, o_valid=0.
- Glitch: resp toggles detected at E1, E2 and E3 (net change).
  - Required: o_latency=3, o_edges=3, o_valid after E7.
- No response: stim change with resp constant.
  - Required: o_latency=0, o_edges=0, o_valid after E4.
- Timeout with TIMEOUT=20: resp toggles every cycle.
  - Required: o_valid after E19, o_timeout=1, o_latency=20, o_edges=15 (saturated).
- Restart and missed: a second stim change at E2 during MEASURE.
  - Required: the window restarts at that edge (new E0).
  - Then change stim while o_valid=1 and no ack -> o_missed=1, and the report values stay unchanged.
